tomasulo_rs: RTL and testbench

//  Reservation station for one functional unit (arith, logic or mpy instance).

---
 rtl/tomasulo_pkg.sv | 91 +++++++++
 rtl/tomasulo_rs_age_matrix.sv | 45 ++++
 rtl/tomasulo_rs.sv | 131 +++++++++++++
 tb/tb_tomasulo_rs.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo reservation station.
// Dispatch, issue and CDB bundles plus the operand snoop helper.
package tomasulo_pkg;

    localparam int RS_N   = 4;
    localparam int TAG_W  = 5;
    localparam int ROB_W  = 4;
    localparam int DATA_W = 32;
    localparam int IMM_W  = 16;
    localparam int WA_W   = 5;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [ROB_W-1:0]  robid_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [IMM_W-1:0]  imm_t;
    typedef logic [WA_W-1:0]   wa_t;

    typedef logic [$clog2(RS_N+1)-1:0] rs_crdt_t;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_NOT,
        OP_MOV0,
        OP_MOV1,
        OP_MOVI,
        OP_MUL
    } opcode_t;

    typedef struct packed {
        logic [DATA_W-TAG_W-1:0] pad;
        tag_t                    tag;
    } oprand_tag_t;

    // Either the operand value or the tag of its producer.
    typedef union packed {
        data_t       w;
        oprand_tag_t t;
    } oprand_u_t;

    typedef struct packed {
        logic      busy;
        oprand_u_t u;
    } oprand_t;

    typedef struct packed {
        opcode_t       opcode;
        tag_t          tag;
        oprand_t [1:0] oprand;
        robid_t        robid;
        imm_t          imm;
        wa_t           wa;
    } dispatch_t;

    typedef struct packed {
        logic   vld;
        tag_t   tag;
        data_t  wdata;
        wa_t    wa;
        robid_t robid;
    } cdb_t;

    typedef struct packed {
        data_t [1:0] rdata;
        opcode_t     op;
        tag_t        tag;
        imm_t        imm;
        robid_t      robid;
        wa_t         wa;
    } issue_t;

    typedef struct packed {
        logic      vld;
        dispatch_t d;
    } rs_entry_t;

    // Replace a waiting operand by the broadcast value when tags match.
    function automatic oprand_t snoop(oprand_t o, cdb_t c);
        oprand_t r;
        r = o;
        if (o.busy && c.vld && (c.tag == o.u.t.tag)) begin
            r.busy = 1'b0;
            r.u.w  = c.wdata;
        end
        return r;
    endfunction

endpackage

// File: rtl/tomasulo_rs_age_matrix.sv
// Age matrix: grants the oldest requesting entry.
// older[i][j] set means entry j was dispatched before entry i.
module tomasulo_rs_age_matrix #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] alloc,
    input  logic [N-1:0] free,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    logic [N-1:0] older [N];

    // New entry is younger than everything; it is older than nobody yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (alloc[i]) begin
                        older[i][j] <= 1'(j != i);
                    end else if (alloc[j]) begin
                        older[i][j] <= 1'b0;
                    end else if (free[i]) begin
                        older[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // Grant a requester with no older requester; stale bits are masked by req.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = req[i] && !(|(older[i] & req));
        end
    end

endmodule

// File: rtl/tomasulo_rs.sv
// Reservation station: holds dispatched ops, snoops the CDB,
// issues the oldest ready entry and returns credits.
module tomasulo_rs
    import tomasulo_pkg::*;
#(
    parameter int N = RS_N
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      disp_vld,
    input  dispatch_t disp,
    input  cdb_t      cdb,
    output logic      iss_vld,
    output issue_t    iss,
    input  logic      iss_rdy,
    output logic      crdt_ret
);

    rs_entry_t    ent [N];
    logic [N-1:0] vld;
    logic [N-1:0] rdy;
    logic [N-1:0] gnt;
    logic [N-1:0] alloc;
    logic [N-1:0] free;
    logic         fire;
    dispatch_t    disp_s;
    logic         unused_cdb;

    assign unused_cdb = ^{cdb.wa, cdb.robid};

    // Per-entry valid and ready (both operands present).
    always_comb begin
        for (int i = 0; i < N; i++) begin
            vld[i] = ent[i].vld;
            rdy[i] = ent[i].vld
                  && !ent[i].d.oprand[0].busy
                  && !ent[i].d.oprand[1].busy;
        end
    end

    // Lowest-index invalid entry takes the dispatch.
    always_comb begin
        alloc = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (!vld[i]) begin
                alloc    = '0;
                alloc[i] = 1'b1;
            end
        end
        if (!disp_vld) begin
            alloc = '0;
        end
    end

    // Incoming operands also see this cycle's broadcast.
    always_comb begin
        disp_s = disp;
        for (int k = 0; k < 2; k++) begin
            disp_s.oprand[k] = snoop(disp.oprand[k], cdb);
        end
    end

    assign iss_vld = |rdy;
    assign fire    = iss_vld && iss_rdy;
    assign free    = fire ? gnt : '0;

    tomasulo_rs_age_matrix #(.N(N)) u_age (
        .clk   (clk),
        .rst   (rst),
        .alloc (alloc),
        .free  (free),
        .req   (rdy),
        .gnt   (gnt)
    );

    // Issue mux driven by the one-hot oldest-ready grant.
    always_comb begin
        iss = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                iss.rdata[0] = ent[i].d.oprand[0].u.w;
                iss.rdata[1] = ent[i].d.oprand[1].u.w;
                iss.op       = ent[i].d.opcode;
                iss.tag      = ent[i].d.tag;
                iss.imm      = ent[i].d.imm;
                iss.robid    = ent[i].d.robid;
                iss.wa       = ent[i].d.wa;
            end
        end
    end

    // Entry state: allocate, retire on issue, or wake waiting operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                ent[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (alloc[i]) begin
                    ent[i].vld <= 1'b1;
                    ent[i].d   <= disp_s;
                end else if (free[i]) begin
                    ent[i].vld <= 1'b0;
                end else if (ent[i].vld) begin
                    for (int k = 0; k < 2; k++) begin
                        ent[i].d.oprand[k] <= snoop(ent[i].d.oprand[k], cdb);
                    end
                end
            end
        end
    end

    // Credit returns the cycle after a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            crdt_ret <= 1'b0;
        end else begin
            crdt_ret <= fire;
        end
    end

    // Dispatch into a full station is a dispatcher bug.
    always_ff @(posedge clk) begin
        if (!rst && disp_vld) begin
            assert (!(&vld))
            else $error("tomasulo_rs: dispatch with no free entry");
        end
    end

endmodule

// File: tb/tb_tomasulo_rs.sv
// Bench for tomasulo_rs: directed scenarios plus random traffic
// compared against an in-order queue model of the station.
module tb_tomasulo_rs;
    import tomasulo_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      disp_vld;
    dispatch_t disp;
    cdb_t      cdb;
    logic      iss_vld;
    issue_t    iss;
    logic      iss_rdy;
    logic      crdt_ret;

    always #5 clk = ~clk;

    tomasulo_rs #(.N(RS_N)) dut (
        .clk      (clk),
        .rst      (rst),
        .disp_vld (disp_vld),
        .disp     (disp),
        .cdb      (cdb),
        .iss_vld  (iss_vld),
        .iss      (iss),
        .iss_rdy  (iss_rdy),
        .crdt_ret (crdt_ret)
    );

    typedef struct {
        opcode_t op;
        tag_t    tag;
        robid_t  robid;
        imm_t    imm;
        wa_t     wa;
        bit      busy [2];
        data_t   val  [2];
        tag_t    src  [2];
    } ment_t;

    ment_t q[$];
    bit    exp_crdt;
    tag_t  seen[$];
    int    crdt_cnt;
    int    checks;
    int    errors;

    task automatic chk(string t, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", t, got, exp);
        end
    endtask

    function automatic int msel();
        foreach (q[i]) begin
            if (!q[i].busy[0] && !q[i].busy[1]) return i;
        end
        return -1;
    endfunction

    function automatic issue_t mexp(int s);
        issue_t e;
        e          = '0;
        e.rdata[0] = q[s].val[0];
        e.rdata[1] = q[s].val[1];
        e.op       = q[s].op;
        e.tag      = q[s].tag;
        e.imm      = q[s].imm;
        e.robid    = q[s].robid;
        e.wa       = q[s].wa;
        return e;
    endfunction

    function automatic ment_t from_disp(dispatch_t d, cdb_t c);
        ment_t m;
        m.op    = d.opcode;
        m.tag   = d.tag;
        m.robid = d.robid;
        m.imm   = d.imm;
        m.wa    = d.wa;
        for (int k = 0; k < 2; k++) begin
            m.src[k]  = d.oprand[k].u.t.tag;
            m.busy[k] = d.oprand[k].busy;
            m.val[k]  = d.oprand[k].u.w;
            if (m.busy[k] && c.vld && c.tag == m.src[k]) begin
                m.busy[k] = 1'b0;
                m.val[k]  = c.wdata;
            end
        end
        return m;
    endfunction

    task automatic model_step();
        int    s;
        bit    f;
        ment_t e;
        if (rst) begin
            q.delete();
            exp_crdt = 1'b0;
            return;
        end
        s = msel();
        f = (s >= 0) && iss_rdy;
        exp_crdt = f;
        if (f) q.delete(s);
        foreach (q[i]) begin
            e = q[i];
            for (int k = 0; k < 2; k++) begin
                if (e.busy[k] && cdb.vld && cdb.tag == e.src[k]) begin
                    e.busy[k] = 1'b0;
                    e.val[k]  = cdb.wdata;
                end
            end
            q[i] = e;
        end
        if (disp_vld) q.push_back(from_disp(disp, cdb));
    endtask

    task automatic check_out();
        int s;
        s = msel();
        chk("iss_vld", iss_vld, s >= 0);
        chk("crdt_ret", crdt_ret, exp_crdt);
        if (s >= 0) chk("iss", iss, mexp(s));
    endtask

    task automatic cyc();
        if (iss_vld && iss_rdy) seen.push_back(iss.tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (crdt_ret) crdt_cnt++;
        check_out();
    endtask

    function automatic oprand_t mk_op(bit b, logic [31:0] v);
        oprand_t o;
        o.busy = b;
        o.u.w  = $urandom;
        if (b) o.u.t.tag = tag_t'(v);
        else   o.u.w     = v;
        return o;
    endfunction

    function automatic dispatch_t mk(opcode_t op, tag_t t,
                                     bit b0, logic [31:0] v0,
                                     bit b1, logic [31:0] v1);
        dispatch_t d;
        d.opcode    = op;
        d.tag       = t;
        d.oprand[0] = mk_op(b0, v0);
        d.oprand[1] = mk_op(b1, v1);
        d.robid     = robid_t'($urandom);
        d.imm       = imm_t'($urandom);
        d.wa        = wa_t'($urandom);
        return d;
    endfunction

    task automatic idle();
        disp_vld = 1'b0;
        disp     = '0;
        cdb      = '0;
    endtask

    task automatic bcast(tag_t t, data_t w);
        cdb       = '0;
        cdb.vld   = 1'b1;
        cdb.tag   = t;
        cdb.wdata = w;
    endtask

    issue_t hold;
    int     c0;

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        iss_rdy = 1'b1;
        idle();
        cyc();
        cyc();
        chk("rst_iss", iss, '0);
        rst = 1'b0;
        cyc();

        // Ready ADD issues next cycle, credit one cycle later.
        disp_vld = 1'b1;
        disp = mk(OP_ADD, 5'd3, 1'b0, 32'd5, 1'b0, 32'd7);
        cyc();
        idle();
        chk("t1_vld", iss_vld, 1'b1);
        chk("t1_rd1", iss.rdata[1], 32'd7);
        chk("t1_rd0", iss.rdata[0], 32'd5);
        chk("t1_tag", iss.tag, 5'd3);
        cyc();
        chk("t1_crdt", crdt_ret, 1'b1);
        cyc();
        chk("t1_crdt_off", crdt_ret, 1'b0);

        // Operand woken by a later broadcast.
        disp_vld = 1'b1;
        disp = mk(OP_SUB, 5'd20, 1'b1, 32'd9, 1'b0, 32'd1);
        cyc();
        idle();
        chk("t2_wait1", iss_vld, 1'b0);
        cyc();
        chk("t2_wait2", iss_vld, 1'b0);
        cyc();
        chk("t2_wait3", iss_vld, 1'b0);
        bcast(5'd9, 32'hDEAD);
        cyc();
        idle();
        chk("t2_vld", iss_vld, 1'b1);
        chk("t2_rd0", iss.rdata[0], 32'hDEAD);
        cyc();
        cyc();

        // Dispatch-cycle bypass.
        disp_vld = 1'b1;
        disp = mk(OP_AND, 5'd21, 1'b1, 32'd4, 1'b0, 32'd2);
        bcast(5'd4, 32'h11);
        cyc();
        idle();
        chk("t3_vld", iss_vld, 1'b1);
        chk("t3_rd0", iss.rdata[0], 32'h11);
        cyc();
        cyc();

        // Fill, wake out of order, issue in dispatch order.
        iss_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp_vld = 1'b1;
            disp = mk(OP_OR, tag_t'(10 + i), 1'b1, 32'(i + 1), 1'b0, 32'(i));
            cyc();
        end
        idle();
        bcast(5'd4, 32'h40); cyc();
        bcast(5'd2, 32'h20); cyc();
        bcast(5'd3, 32'h30); cyc();
        bcast(5'd1, 32'h10); cyc();
        idle();
        seen.delete();
        crdt_cnt = 0;
        iss_rdy  = 1'b1;
        repeat (6) cyc();
        chk("t4_cnt", seen.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) chk("t4_order", seen[i], 10 + i);
        end
        chk("t4_crdt", crdt_cnt, 4);

        // Back-pressure holds the issue bundle.
        iss_rdy = 1'b0;
        disp_vld = 1'b1;
        disp = mk(OP_XOR, 5'd22, 1'b0, 32'd1, 1'b0, 32'd2);
        cyc();
        disp = mk(OP_MUL, 5'd23, 1'b0, 32'd3, 1'b0, 32'd4);
        cyc();
        idle();
        hold = iss;
        crdt_cnt = 0;
        repeat (5) begin
            cyc();
            chk("t5_hold", iss, hold);
        end
        chk("t5_nocrdt", crdt_cnt, 0);
        seen.delete();
        iss_rdy = 1'b1;
        cyc();
        cyc();
        chk("t5_b2b", seen.size(), 2);
        cyc();

        // Reset drops held entries.
        iss_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp_vld = 1'b1;
            disp = mk(OP_NOT, tag_t'(24 + i), 1'b1, 32'(5 + i), 1'b0, 32'd0);
            cyc();
        end
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_vld", iss_vld, 1'b0);
        chk("t6_crdt", crdt_ret, 1'b0);
        iss_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bcast(tag_t'(5 + i), 32'h77);
            cyc();
            chk("t6_quiet", iss_vld, 1'b0);
        end
        idle();
        cyc();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 299) == 0);
            iss_rdy = ($urandom_range(0, 3) != 0);
            idle();
            if (q.size() < RS_N && $urandom_range(0, 1) == 1) begin
                disp_vld = 1'b1;
                disp = mk(opcode_t'($urandom_range(0, 9)),
                          tag_t'($urandom),
                          1'($urandom), $urandom_range(0, 7),
                          1'($urandom), $urandom_range(0, 7));
                if (!disp.oprand[0].busy) disp.oprand[0].u.w = $urandom;
                if (!disp.oprand[1].busy) disp.oprand[1].u.w = $urandom;
            end
            if ($urandom_range(0, 1) == 1) begin
                bcast(tag_t'($urandom_range(0, 7)), $urandom);
            end
            cyc();
        end
        rst = 1'b0;
        idle();
        c0 = checks;
        cyc();
        chk("ran_cnt", checks > c0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
